bus_sched: RTL and testbench

- Slot-based system-bus scheduler running at 16 MHz.
- Divides each 1 µs CPU cycle into 16 phases and generates the 6502 clock, bus-enable and RDY signals.
- Time-shares the RAM/IO bus between the CPU, the SPI1 bridge and a future video fetcher, and sequences CPU reset.
- Replaces the existing timing block; main uses its enables to gate ram_oe/ram_we and the bus output enables.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_sched_cpu_reset_gen.sv | 55 +++++
 rtl/bus_sched.sv | 100 ++++++++++
 tb/tb_bus_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared phase type and slot map for the 16-phase bus scheduler.
// One frame of phases 0..15 spans one 1 us CPU cycle.
package bus_pkg;

  typedef logic [3:0] phase_t;

  localparam phase_t PH_SAMPLE       = 4'd15;
  localparam phase_t PH_SPI_EN_FIRST = 4'd1;
  localparam phase_t PH_SPI_EN_LAST  = 4'd2;
  localparam phase_t PH_SPI_DONE     = 4'd3;
  localparam phase_t PH_VID_EN_FIRST = 4'd5;
  localparam phase_t PH_VID_EN_LAST  = 4'd6;
  localparam phase_t PH_VID_DONE     = 4'd7;
  localparam phase_t PH_CPU_EN_FIRST = 4'd10;
  localparam phase_t PH_CPU_EN_LAST  = 4'd14;
  localparam phase_t PH_PHI2         = 4'd8;

  function automatic logic in_win(
    input phase_t p,
    input phase_t lo,
    input phase_t hi
  );
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/bus_sched_cpu_reset_gen.sv
// CPU reset sequencer: holds cpu_res_o for whole frames after
// any reset source, releasing only on a frame boundary.
module cpu_reset_gen #(
  parameter int RESET_FRAMES = 8
) (
  input  logic clk16_i,
  input  logic reset_ni,
  input  logic cpu_reset_req_i,
  input  logic wrap,
  output logic cpu_res_o,
  output logic res_next
);

  localparam int CW =
    (RESET_FRAMES < 1) ? 1 : $clog2(RESET_FRAMES + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LOAD = cnt_t'(RESET_FRAMES);

  cnt_t cnt_q;
  cnt_t cnt_d;
  logic part_q;
  logic part_d;

  // A request landing mid-frame marks the remainder of that
  // frame as partial so it is not counted as a reset frame.
  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    if (cpu_reset_req_i) begin
      cnt_d  = LOAD;
      part_d = !wrap;
    end else if (wrap) begin
      if (part_q)
        part_d = 1'b0;
      else if (cnt_q != '0)
        cnt_d = cnt_q - cnt_t'(1);
    end
    res_next = cpu_reset_req_i || part_d || (cnt_d != '0);
  end

  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q     <= LOAD;
      part_q    <= 1'b0;
      cpu_res_o <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      cpu_res_o <= res_next;
    end
  end

endmodule

// File: rtl/bus_sched.sv
// Slot-based bus scheduler: 6502 clocking, bus enables and RDY,
// plus frame-granted SPI and video windows on the shared bus.
module bus_sched
  import bus_pkg::*;
#(
  parameter int RESET_FRAMES = 8,
  parameter bit VIDEO_EN     = 1'b1
) (
  input  logic       clk16_i,
  input  logic       reset_ni,
  output logic       clk8_o,
  output logic [3:0] phase_o,
  output logic       cpu_clk_o,
  output logic       cpu_be_o,
  output logic       cpu_ready_o,
  output logic       cpu_res_o,
  output logic       cpu_en_o,
  input  logic       cpu_stop_i,
  input  logic       cpu_reset_req_i,
  input  logic       spi_valid_i,
  output logic       spi_en_o,
  output logic       spi_ready_o,
  input  logic       vid_req_i,
  output logic       vid_en_o,
  output logic       vid_ack_o
);

  phase_t phase_q;
  phase_t ph_d;
  logic   wrap;
  logic   res_next;
  logic   spi_gnt_q;
  logic   vid_gnt_q;
  logic   spi_gnt_d;
  logic   vid_gnt_d;

  assign ph_d    = phase_q + 4'd1;
  assign wrap    = (phase_q == PH_SAMPLE);
  assign phase_o = phase_q;

  // Grants latch on the wrap edge and cover the whole next frame.
  always_comb begin
    spi_gnt_d = spi_gnt_q;
    vid_gnt_d = vid_gnt_q;
    if (wrap) begin
      spi_gnt_d = spi_valid_i;
      vid_gnt_d = vid_req_i && VIDEO_EN;
    end
  end

  cpu_reset_gen #(
    .RESET_FRAMES(RESET_FRAMES)
  ) u_rst (
    .clk16_i        (clk16_i),
    .reset_ni       (reset_ni),
    .cpu_reset_req_i(cpu_reset_req_i),
    .wrap           (wrap),
    .cpu_res_o      (cpu_res_o),
    .res_next       (res_next)
  );

  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q     <= '0;
      spi_gnt_q   <= 1'b0;
      vid_gnt_q   <= 1'b0;
      clk8_o      <= 1'b0;
      cpu_clk_o   <= 1'b0;
      cpu_be_o    <= 1'b0;
      cpu_ready_o <= 1'b0;
      cpu_en_o    <= 1'b0;
      spi_en_o    <= 1'b0;
      spi_ready_o <= 1'b0;
      vid_en_o    <= 1'b0;
      vid_ack_o   <= 1'b0;
    end else begin
      phase_q   <= ph_d;
      spi_gnt_q <= spi_gnt_d;
      vid_gnt_q <= vid_gnt_d;
      clk8_o    <= !clk8_o;
      cpu_clk_o <= (ph_d >= PH_PHI2);
      cpu_be_o  <= !((ph_d < PH_PHI2) &&
                     (spi_gnt_d || vid_gnt_d));
      // RDY only moves entering PHI2 so it is stable across it.
      if (ph_d == PH_PHI2)
        cpu_ready_o <= !cpu_stop_i;
      cpu_en_o <= in_win(ph_d, PH_CPU_EN_FIRST,
                         PH_CPU_EN_LAST) && !res_next;
      spi_en_o <= spi_gnt_d &&
                  in_win(ph_d, PH_SPI_EN_FIRST,
                         PH_SPI_EN_LAST);
      spi_ready_o <= spi_gnt_d && (ph_d == PH_SPI_DONE);
      vid_en_o <= vid_gnt_d &&
                  in_win(ph_d, PH_VID_EN_FIRST,
                         PH_VID_EN_LAST);
      vid_ack_o <= vid_gnt_d && (ph_d == PH_VID_DONE);
    end
  end

endmodule

// File: tb/tb_bus_sched.sv
// Scoreboard bench for bus_sched: a frame-level reference model
// predicts every cycle; a monitor compares after each clock edge.
module tb_bus_sched;

  localparam int RF = 8;

  logic clk;
  logic rst;
  logic spi_v;
  logic vid_r;
  logic stop;
  logic req;

  logic       a_c8, a_cc, a_be, a_rd, a_res, a_cen;
  logic       a_sen, a_srd, a_ven, a_vak;
  logic [3:0] a_ph;
  logic       b_c8, b_cc, b_be, b_rd, b_res, b_cen;
  logic       b_sen, b_srd, b_ven, b_vak;
  logic [3:0] b_ph;

  bus_sched #(.RESET_FRAMES(RF), .VIDEO_EN(1'b1)) dut_a (
    .clk16_i(clk), .reset_ni(rst),
    .clk8_o(a_c8), .phase_o(a_ph),
    .cpu_clk_o(a_cc), .cpu_be_o(a_be),
    .cpu_ready_o(a_rd), .cpu_res_o(a_res),
    .cpu_en_o(a_cen), .cpu_stop_i(stop),
    .cpu_reset_req_i(req), .spi_valid_i(spi_v),
    .spi_en_o(a_sen), .spi_ready_o(a_srd),
    .vid_req_i(vid_r), .vid_en_o(a_ven),
    .vid_ack_o(a_vak)
  );

  bus_sched #(.RESET_FRAMES(RF), .VIDEO_EN(1'b0)) dut_b (
    .clk16_i(clk), .reset_ni(rst),
    .clk8_o(b_c8), .phase_o(b_ph),
    .cpu_clk_o(b_cc), .cpu_be_o(b_be),
    .cpu_ready_o(b_rd), .cpu_res_o(b_res),
    .cpu_en_o(b_cen), .cpu_stop_i(stop),
    .cpu_reset_req_i(req), .spi_valid_i(spi_v),
    .spi_en_o(b_sen), .spi_ready_o(b_srd),
    .vid_req_i(vid_r), .vid_en_o(b_ven),
    .vid_ack_o(b_vak)
  );

  typedef struct {
    logic [3:0] ph;
    logic c8, cc, be, rd, res, cen;
    logic sen, srd, ven, vak, be_b;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;

  // Reference state: m = edges since reset release,
  // last = edge of most recent cpu_reset_req sample.
  int m;
  int last;
  bit sg, vg, rdy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, req_v, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    int n, p, rel;
    if (!rst) begin
      m = 0; last = 0;
      sg = 0; vg = 0; rdy = 0;
      e.ph = 0; e.c8 = 0; e.cc = 0;
      e.be = 0; e.rd = 0; e.res = 1;
      e.cen = 0; e.sen = 0; e.srd = 0;
      e.ven = 0; e.vak = 0; e.be_b = 0;
    end else begin
      n = m + 1;
      p = n % 16;
      if (p == 0) begin
        sg = spi_v;
        vg = vid_r;
      end
      if (p == 8) rdy = !stop;
      if (req) last = n;
      // Release at the frame start on/after the request,
      // plus RF whole frames.
      rel = ((last + 15) / 16) * 16 + 16 * RF;
      m = n;
      e.ph = 4'(p);
      e.c8 = (p % 2) == 1;
      e.cc = p >= 8;
      e.be = !(p < 8 && (sg || vg));
      e.be_b = !(p < 8 && sg);
      e.rd = rdy;
      e.res = n < rel;
      e.cen = p >= 10 && p <= 14 && !(n < rel);
      e.sen = sg && (p == 1 || p == 2);
      e.srd = sg && p == 3;
      e.ven = vg && (p == 5 || p == 6);
      e.vak = vg && p == 7;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to(input int k);
    while ((m % 16) != k) tick();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Monitor: one prediction per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("phase", a_ph, e.ph);
        chk("clk8", a_c8, e.c8);
        chk("cpu_clk", a_cc, e.cc);
        chk("cpu_be", a_be, e.be);
        chk("cpu_ready", a_rd, e.rd);
        chk("cpu_res", a_res, e.res);
        chk("cpu_en", a_cen, e.cen);
        chk("spi_en", a_sen, e.sen);
        chk("spi_ready", a_srd, e.srd);
        chk("vid_en", a_ven, e.ven);
        chk("vid_ack", a_vak, e.vak);
        chk("overlap", a_sen & a_ven, 0);
        chk("b_vid_en", b_ven, 0);
        chk("b_vid_ack", b_vak, 0);
        chk("b_cpu_be", b_be, e.be_b);
        chk("b_spi_ready", b_srd, e.srd);
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; spi_v = 0; vid_r = 0;
    stop = 0; req = 0;
    m = 0; last = 0; sg = 0; vg = 0; rdy = 0;
    @(negedge clk);
    ticks(3);
    rst = 1'b1;
    ticks(150);

    // Single SPI transaction requested in phase 4.
    run_to(4); spi_v = 1; tick();
    run_to(4); spi_v = 0;
    ticks(20);

    // SPI and video together, raised in phase 12.
    run_to(12); spi_v = 1; vid_r = 1; tick();
    run_to(8); spi_v = 0; vid_r = 0;

    // Short request dropped before sampling.
    run_to(3); spi_v = 1; ticks(5); spi_v = 0;
    ticks(20);

    // RDY stop/restart.
    run_to(3); stop = 1; tick();
    run_to(9); stop = 0; tick();
    ticks(32);

    // CPU reset request pulse mid-frame.
    run_to(6); req = 1; tick(); req = 0;
    ticks(150);

    // Async reset during an SPI window.
    run_to(10); spi_v = 1; tick();
    run_to(2);
    #2;
    chk("pre_rst_spi_en", a_sen, 1);
    rst = 1'b0;
    #1;
    chk("async_spi_en", a_sen, 0);
    chk("async_res", a_res, 1);
    chk("async_phase", a_ph, 0);
    spi_v = 0;
    @(negedge clk);
    ticks(4);
    rst = 1'b1;
    ticks(140);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) spi_v = !spi_v;
      if ($urandom_range(5) == 0) vid_r = !vid_r;
      if ($urandom_range(31) == 0) stop = !stop;
      req = ($urandom_range(399) == 0);
      tick();
    end
    req = 0;
    ticks(4);
    @(posedge clk);
    #2;
    chk("queue_drained", 4'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
